// File: rtl/beamscaler_pkg.sv
// Shared constants, frame FSM state and header/trailer beat layouts for the scaler readout.
package beamscaler_pkg;

  localparam logic [7:0] HDR_MAGIC      = 8'hBE;
  localparam logic [7:0] TRL_MAGIC      = 8'hED;
  localparam int         RAM_RD_LATENCY = 2;
  localparam int         RDFIFO_DEPTH   = 4;
  localparam int         RDFIFO_AW      = $clog2(RDFIFO_DEPTH);
  localparam int         RDFIFO_CW      = $clog2(RDFIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_TRAILER
  } frame_state_t;

  typedef struct packed {
    logic [7:0] magic;
    logic [7:0] seq;
    logic [6:0] rsvd;
    logic       bank;
    logic [7:0] nwords;
  } hdr_t;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  seq;
    logic [14:0] rsvd;
    logic        overrun;
  } trl_t;

endpackage

// File: rtl/beamscaler_readout_if.sv
// Signals between the readout, the scaler wrapper (timer, done, RAM port) and the stream sink.
interface beamscaler_readout_if;
  logic [31:0] scal_period_i;
  logic        scal_period_wr_i;
  logic        timer_o;
  logic        done_i;
  logic        write_bank_i;
  logic        scal_rd_o;
  logic [6:0]  scal_adr_o;
  logic [31:0] scal_dat_i;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    input  scal_period_i, scal_period_wr_i, done_i, write_bank_i, scal_dat_i, m_axis_tready,
    output timer_o, scal_rd_o, scal_adr_o, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output scal_period_i, scal_period_wr_i, done_i, write_bank_i, scal_dat_i, m_axis_tready,
    input  timer_o, scal_rd_o, scal_adr_o, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/beamscaler_rdfifo.sv
// Small first-word-fall-through FIFO catching RAM read data; head word is visible while not empty.
module beamscaler_rdfifo
  import beamscaler_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 i_wr_vld,
  input  logic [DW-1:0]        i_wr_dat,
  input  logic                 i_pop,
  output logic [DW-1:0]        o_rd_dat,
  output logic                 o_empty,
  output logic [RDFIFO_CW-1:0] o_count
);

  logic [DW-1:0]        r_mem [RDFIFO_DEPTH];
  logic [RDFIFO_AW-1:0] r_wptr;
  logic [RDFIFO_AW-1:0] r_rptr;
  logic [RDFIFO_CW-1:0] r_count;
  logic                 w_wr;
  logic                 w_rd;

  assign w_wr = i_wr_vld && (r_count != RDFIFO_CW'(RDFIFO_DEPTH));
  assign w_rd = i_pop && (r_count != '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[r_rptr];
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

endmodule

// File: rtl/beamscaler_readout.sv
// Drains the scaler RAM after each bank update into one framed AXI4-Stream packet, and
// generates the scaler update timer when BEAMSCALER_READOUT_TIMER_EN is defined (else timer_o = 0).
module beamscaler_readout
  import beamscaler_pkg::*;
#(
  parameter int          NBEAMS         = 48,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd12_500_000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  beamscaler_readout_if.master io_scal
);

  localparam int         NWORDS = (NBEAMS + 1) / 2;
  localparam logic [7:0] NW8    = 8'(NWORDS);

  frame_state_t r_state, w_state_nxt;
  logic        r_tvalid, w_tvalid_nxt;
  logic        r_tlast, w_tlast_nxt;
  logic [31:0] r_tdata, w_tdata_nxt;
  logic        r_rd, w_rd_nxt;
  logic [6:0]  r_adr, w_adr_nxt;
  logic [7:0]  r_rd_cnt, w_rd_cnt_nxt;
  logic [7:0]  r_dcnt, w_dcnt_nxt;
  logic        r_ovr, w_ovr_nxt;
  logic [7:0]  r_seq, w_seq_nxt;
  logic [RAM_RD_LATENCY-1:0] r_rd_pipe;

  logic                 w_hs;
  logic                 w_slot_free;
  logic                 w_pop;
  logic [3:0]           w_used;
  logic                 w_fifo_empty;
  logic [31:0]          w_fifo_dat;
  logic [RDFIFO_CW-1:0] w_fifo_cnt;
  hdr_t                 w_hdr;
  trl_t                 w_trl;

  beamscaler_rdfifo #(.DW(32)) u_rdfifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .i_wr_vld (r_rd_pipe[RAM_RD_LATENCY-1]),
    .i_wr_dat (io_scal.scal_dat_i),
    .i_pop    (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_empty  (w_fifo_empty),
    .o_count  (w_fifo_cnt)
  );

  assign w_hs        = r_tvalid && io_scal.m_axis_tready;
  assign w_slot_free = !r_tvalid || io_scal.m_axis_tready;

  always_comb begin
    w_state_nxt  = r_state;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_tdata_nxt  = r_tdata;
    w_dcnt_nxt   = r_dcnt;
    w_seq_nxt    = r_seq;
    w_ovr_nxt    = r_ovr | (io_scal.done_i && (r_state != ST_IDLE));
    w_pop        = 1'b0;

    w_hdr.magic  = HDR_MAGIC;
    w_hdr.seq    = r_seq;
    w_hdr.rsvd   = '0;
    w_hdr.bank   = !io_scal.write_bank_i;
    w_hdr.nwords = NW8;

    // A done pulse landing with the last data handshake still marks this trailer.
    w_trl.magic   = TRL_MAGIC;
    w_trl.seq     = r_seq;
    w_trl.rsvd    = '0;
    w_trl.overrun = r_ovr | io_scal.done_i;

    case (r_state)
      ST_IDLE: begin
        if (io_scal.done_i) begin
          w_state_nxt  = ST_HEADER;
          w_ovr_nxt    = 1'b0;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = 1'b0;
          w_tdata_nxt  = w_hdr;
          w_dcnt_nxt   = '0;
        end
      end
      ST_HEADER: begin
        if (w_hs) begin
          w_state_nxt  = ST_DATA;
          w_tvalid_nxt = !w_fifo_empty;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_tdata_nxt = w_fifo_dat;
          end
        end
      end
      ST_DATA: begin
        if (w_hs) w_dcnt_nxt = r_dcnt + 8'd1;
        if (w_slot_free) begin
          if (w_dcnt_nxt == NW8) begin
            w_state_nxt  = ST_TRAILER;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b1;
            w_tdata_nxt  = w_trl;
          end else if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = w_fifo_dat;
          end else begin
            w_tvalid_nxt = 1'b0;
          end
        end
      end
      ST_TRAILER: begin
        if (w_hs) begin
          w_state_nxt  = ST_IDLE;
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
          w_seq_nxt    = r_seq + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Credit: words held or owed to the FIFO after this edge's pop must leave room for one more.
    w_used = 4'(w_fifo_cnt) + 4'(r_rd) - 4'(w_pop);
    for (int i = 0; i < RAM_RD_LATENCY; i++) w_used = w_used + 4'(r_rd_pipe[i]);

    w_rd_nxt     = 1'b0;
    w_adr_nxt    = r_adr;
    w_rd_cnt_nxt = r_rd_cnt;
    if (r_state == ST_IDLE) begin
      if (io_scal.done_i) begin
        w_rd_nxt     = 1'b1;
        w_adr_nxt    = '0;
        w_rd_cnt_nxt = 8'd1;
      end
    end else if ((r_rd_cnt < NW8) && (w_used < 4'(RDFIFO_DEPTH))) begin
      w_rd_nxt     = 1'b1;
      w_adr_nxt    = r_rd_cnt[6:0];
      w_rd_cnt_nxt = r_rd_cnt + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
      r_rd      <= 1'b0;
      r_adr     <= '0;
      r_rd_cnt  <= '0;
      r_dcnt    <= '0;
      r_ovr     <= 1'b0;
      r_seq     <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tvalid  <= w_tvalid_nxt;
      r_tlast   <= w_tlast_nxt;
      r_tdata   <= w_tdata_nxt;
      r_rd      <= w_rd_nxt;
      r_adr     <= w_adr_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_ovr     <= w_ovr_nxt;
      r_seq     <= w_seq_nxt;
      r_rd_pipe <= {r_rd_pipe[RAM_RD_LATENCY-2:0], r_rd};
    end
  end

  assign io_scal.m_axis_tvalid = r_tvalid;
  assign io_scal.m_axis_tlast  = r_tlast;
  assign io_scal.m_axis_tdata  = r_tdata;
  assign io_scal.scal_rd_o     = r_rd;
  assign io_scal.scal_adr_o    = r_adr;

`ifdef BEAMSCALER_READOUT_TIMER_EN
  logic [31:0] r_period;
  logic [31:0] r_tcnt;
  logic        r_timer;

  // Period 0 parks the counter at 0 without pulsing.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_period <= DEFAULT_PERIOD;
      r_tcnt   <= DEFAULT_PERIOD;
      r_timer  <= 1'b0;
    end else if (io_scal.scal_period_wr_i) begin
      r_period <= io_scal.scal_period_i;
      r_tcnt   <= io_scal.scal_period_i;
      r_timer  <= 1'b0;
    end else if (r_period == '0) begin
      r_timer  <= 1'b0;
    end else if (r_tcnt == '0) begin
      r_tcnt   <= r_period;
      r_timer  <= 1'b1;
    end else begin
      r_tcnt   <= r_tcnt - 32'd1;
      r_timer  <= 1'b0;
    end
  end

  assign io_scal.timer_o = r_timer;
`else
  logic w_unused;
  assign w_unused        = ^{io_scal.scal_period_i, io_scal.scal_period_wr_i, DEFAULT_PERIOD};
  assign io_scal.timer_o = 1'b0;
`endif

endmodule

// File: tb/tb_beamscaler_readout.sv
// Directed bench for beamscaler_readout: frames, backpressure, overrun, timer, reset, seq wrap.
module tb_beamscaler_readout;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   stab_err = 0;
  int   seq_e = 0;
  bit   bp_en = 1'b0;
  logic [31:0] salt = '0;

  beamscaler_readout_if bus();

  beamscaler_readout #(.NBEAMS(48)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_scal  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [6:0] a);
    return {4{1'b0, a}} ^ salt;
  endfunction

  // RAM model: data valid two cycles after the read strobe.
  logic [31:0] rd_d1;
  always @(posedge clk) begin
    rd_d1          <= bus.scal_rd_o ? ram_word(bus.scal_adr_o) : 32'hDEAD_BEEF;
    bus.scal_dat_i <= rd_d1;
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  logic [32:0] beats[$];
  int          beat_cyc[$];
  logic [6:0]  addrs[$];
  int          tp[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
        beat_cyc.push_back(cyc);
      end
      if (bus.scal_rd_o) addrs.push_back(bus.scal_adr_o);
      if (bus.timer_o) tp.push_back(cyc);
      if (prev_stall && (!bus.m_axis_tvalid || ({bus.m_axis_tlast, bus.m_axis_tdata} != prev_beat)))
        stab_err++;
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_beat  = {bus.m_axis_tlast, bus.m_axis_tdata};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    beat_cyc.delete();
    addrs.delete();
  endtask

  task automatic pulse_done(input logic wb);
    @(posedge clk);
    #1;
    bus.done_i       = 1'b1;
    bus.write_bank_i = wb;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (beats.size() < n) check_eq("timeout", 64'(beats.size()), 64'(n));
  endtask

  task automatic check_frame(input string tag, input logic bank, input logic [7:0] seq, input logic ovr);
    logic [32:0] e;
    check_eq({tag, "_len"}, 64'(beats.size()), 64'd26);
    if (beats.size() == 26) begin
      e = {1'b0, 8'hBE, seq, 7'b0, bank, 8'd24};
      check_eq({tag, "_hdr"}, 64'(beats[0]), 64'(e));
      for (int i = 1; i <= 24; i++)
        check_eq({tag, "_dat"}, 64'(beats[i]), 64'({1'b0, ram_word(7'(i - 1))}));
      e = {1'b1, 8'hED, seq, 15'b0, ovr};
      check_eq({tag, "_trl"}, 64'(beats[25]), 64'(e));
    end
  endtask

  task automatic check_addrs(input string tag);
    check_eq({tag, "_nrd"}, 64'(addrs.size()), 64'd24);
    for (int i = 0; i < addrs.size() && i < 24; i++)
      check_eq({tag, "_adr"}, 64'(addrs[i]), 64'(i));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    check_eq({tag, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    check_eq({tag, "_tdata"}, 64'(bus.m_axis_tdata), 64'd0);
    check_eq({tag, "_rd"}, 64'(bus.scal_rd_o), 64'd0);
    check_eq({tag, "_adr"}, 64'(bus.scal_adr_o), 64'd0);
    check_eq({tag, "_timer"}, 64'(bus.timer_o), 64'd0);
  endtask

  initial begin
    int wcyc;
    rst                  = 1'b1;
    bus.done_i           = 1'b0;
    bus.write_bank_i     = 1'b0;
    bus.scal_period_i    = '0;
    bus.scal_period_wr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic frame with latency and streaming checks.
    clear_mon();
    @(posedge clk);
    #1;
    bus.done_i       = 1'b1;
    bus.write_bank_i = 1'b0;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
    check_eq("hdr_lat", 64'(bus.m_axis_tvalid), 64'd1);
    check_eq("rd_lat", 64'(bus.scal_rd_o), 64'd1);
    check_eq("rd_adr0", 64'(bus.scal_adr_o), 64'd0);
    wait_beats(26, 200);
    check_frame("basic", 1'b1, 8'(seq_e), 1'b0);
    check_addrs("basic");
    if (beat_cyc.size() == 26) begin
      check_eq("first_data_gap", 64'(beat_cyc[1] - beat_cyc[0] >= 2), 64'd1);
      check_eq("stream_rate", 64'(beat_cyc[25] - beat_cyc[1]), 64'd24);
    end
    seq_e++;

    // Random backpressure, other bank.
    salt = 32'h5A5A_0000;
    clear_mon();
    bp_en = 1'b1;
    pulse_done(1'b1);
    wait_beats(26, 3000);
    bp_en = 1'b0;
    check_frame("bp", 1'b0, 8'(seq_e), 1'b0);
    check_addrs("bp");
    check_eq("bp_stable", 64'(stab_err), 64'd0);
    seq_e++;

    // Overrun mid-DATA.
    salt = 32'h0000_A5A5;
    clear_mon();
    pulse_done(1'b0);
    wait_beats(4, 200);
    pulse_done(1'b0);
    wait_beats(26, 200);
    repeat (60) @(posedge clk);
    #1;
    check_frame("ovr", 1'b1, 8'(seq_e), 1'b1);
    check_eq("ovr_nrd", 64'(addrs.size()), 64'd24);
    seq_e++;
    clear_mon();
    pulse_done(1'b0);
    wait_beats(26, 200);
    check_frame("after_ovr", 1'b1, 8'(seq_e), 1'b0);
    seq_e++;

    // done_i coincident with the trailer handshake is dropped.
    clear_mon();
    pulse_done(1'b0);
    for (int k = 0; k < 200 && !(bus.m_axis_tvalid && bus.m_axis_tlast); k++) begin
      @(posedge clk);
      #1;
    end
    bus.done_i = 1'b1;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_eq("trl_sim_nbeats", 64'(beats.size()), 64'd26);
    seq_e++;
    clear_mon();
    pulse_done(1'b0);
    wait_beats(26, 200);
    check_frame("post_sim", 1'b1, 8'(seq_e), 1'b0);
    seq_e++;

    // Timer.
    tp.delete();
    @(posedge clk);
    #1;
    bus.scal_period_i    = 32'd9;
    bus.scal_period_wr_i = 1'b1;
    wcyc                 = cyc;
    @(posedge clk);
    #1;
    bus.scal_period_wr_i = 1'b0;
    repeat (45) @(posedge clk);
    #1;
`ifdef BEAMSCALER_READOUT_TIMER_EN
    check_eq("tmr_npulse", 64'(tp.size()), 64'd4);
    for (int i = 0; i < tp.size() && i < 4; i++)
      check_eq("tmr_at", 64'(tp[i]), 64'(wcyc + 11 + 10 * i));
    tp.delete();
    bus.scal_period_i    = 32'd0;
    bus.scal_period_wr_i = 1'b1;
    @(posedge clk);
    #1;
    bus.scal_period_wr_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("tmr_off", 64'(tp.size()), 64'd0);
`else
    check_eq("tmr_absent", 64'(tp.size()), 64'd0);
`endif

    // Reset mid-frame.
    clear_mon();
    pulse_done(1'b0);
    wait_beats(6, 200);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    seq_e = 0;
    clear_mon();
    pulse_done(1'b0);
    wait_beats(26, 200);
    check_frame("post_rst", 1'b1, 8'(seq_e), 1'b0);

    // Sequence wrap: frames seq 1..255, then the 257th frame since reset is seq 0.
    for (int f = 1; f <= 255; f++) begin
      clear_mon();
      pulse_done(1'b0);
      wait_beats(26, 200);
    end
    if (beats.size() == 26)
      check_eq("wrap_255_trl", 64'(beats[25]), 64'({1'b1, 8'hED, 8'hFF, 16'h0000}));
    else
      check_eq("wrap_255_len", 64'(beats.size()), 64'd26);
    clear_mon();
    pulse_done(1'b0);
    wait_beats(26, 200);
    check_frame("wrap", 1'b1, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
